// File: rtl/uart_rx_shift.sv
// Serial-to-parallel receive stage: synchronises rx_in, finds the start bit and
// samples every frame bit at mid-bit, presenting the LSB-first frame word on completion.
module uart_rx_shift #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 1,
    parameter int STOP_BITS  = 1,
    parameter int OVERSAMPLE = 16
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         baud_tick,
    input  logic                                         rx_in,
    output logic [DATA_BITS+PARITY_EN+STOP_BITS:0]       data_parll,
    output logic                                         recieved_flag,
    output logic                                         busy
);

    localparam int FRAME_W = 1 + DATA_BITS + PARITY_EN + STOP_BITS;
    localparam int TICK_W  = $clog2(OVERSAMPLE);
    localparam int IDX_W   = $clog2(FRAME_W);

    localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [IDX_W-1:0]  IDX_FIRST = IDX_W'(1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(FRAME_W - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        SHIFT,
        WAIT_IDLE
    } state_t;

    state_t               state;
    logic                 rx_meta;
    logic                 rx_s;
    logic [TICK_W-1:0]    tick_cnt;
    logic [IDX_W-1:0]     bit_idx;
    logic [FRAME_W-1:0]   shreg;
    logic [FRAME_W-1:0]   frame_next;

    // Both synchroniser stages reset high so reset never looks like a start edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx_in;
            rx_s    <= rx_meta;
        end
    end

    // shreg with the current sample merged in at bit_idx; lets the final stop
    // bit reach data_parll on the same edge it is sampled.
    genvar gi;
    generate
        for (gi = 0; gi < FRAME_W; gi++) begin : g_merge
            assign frame_next[gi] = (bit_idx == IDX_W'(gi)) ? rx_s : shreg[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            tick_cnt      <= '0;
            bit_idx       <= '0;
            shreg         <= '1;
            data_parll    <= '1;
            recieved_flag <= 1'b0;
            busy          <= 1'b0;
        end else begin
            recieved_flag <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state    <= START;
                        tick_cnt <= '0;
                        busy     <= 1'b1;
                    end
                end
                START: begin
                    if (baud_tick) begin
                        if (tick_cnt == TICK_MID) begin
                            tick_cnt <= '0;
                            if (!rx_s) begin
                                shreg[0] <= 1'b0;
                                bit_idx  <= IDX_FIRST;
                                state    <= SHIFT;
                            end else begin
                                // Glitch shorter than half a bit: drop it silently.
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    if (baud_tick) begin
                        if (tick_cnt == TICK_LAST) begin
                            tick_cnt <= '0;
                            shreg    <= frame_next;
                            if (bit_idx == IDX_LAST) begin
                                data_parll    <= frame_next;
                                recieved_flag <= 1'b1;
                                busy          <= 1'b0;
                                state         <= rx_s ? IDLE : WAIT_IDLE;
                            end else begin
                                bit_idx <= bit_idx + 1'b1;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end
                WAIT_IDLE: begin
                    // A held-low line must rise before another start is accepted.
                    if (rx_s) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_shift.sv
// Bench for uart_rx_shift: a default instance and an alternate-parameter instance
// fed serial frames; flags are logged and compared with frame words built from the data.
module tb_uart_rx_shift;

    localparam int OS_A = 16;
    localparam int OS_B = 8;
    localparam int FW   = 11;
    localparam int TDIV = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        baud_tick = 1'b0;
    logic        rx_a = 1'b1;
    logic        rx_b = 1'b1;
    logic [10:0] data_a;
    logic [10:0] data_b;
    logic        flag_a;
    logic        flag_b;
    logic        busy_a;
    logic        busy_b;

    int checks   = 0;
    int failures = 0;
    int tick_num = 0;
    int div_cnt  = 0;

    typedef struct {
        logic [10:0] data;
        int          tick;
        logic        busy;
        logic        prev_busy;
    } flag_ev_t;

    flag_ev_t q_a[$];
    flag_ev_t q_b[$];
    logic     prev_busy_a = 1'b0;
    logic     prev_busy_b = 1'b0;

    uart_rx_shift dut_a (
        .clk           (clk),
        .rst           (rst),
        .baud_tick     (baud_tick),
        .rx_in         (rx_a),
        .data_parll    (data_a),
        .recieved_flag (flag_a),
        .busy          (busy_a)
    );

    uart_rx_shift #(
        .DATA_BITS  (8),
        .PARITY_EN  (0),
        .STOP_BITS  (2),
        .OVERSAMPLE (OS_B)
    ) dut_b (
        .clk           (clk),
        .rst           (rst),
        .baud_tick     (baud_tick),
        .rx_in         (rx_b),
        .data_parll    (data_b),
        .recieved_flag (flag_b),
        .busy          (busy_b)
    );

    initial forever #5 clk = ~clk;

    // Tick strobe changes on the falling edge, so it is stable at every rising edge.
    initial forever begin
        @(negedge clk);
        div_cnt   = (div_cnt == TDIV - 1) ? 0 : div_cnt + 1;
        baud_tick = (div_cnt == 0);
        if (baud_tick) tick_num++;
    end

    initial begin
        flag_ev_t ev;
        forever begin
            @(posedge clk);
            #1;
            if (flag_a) begin
                ev.data = data_a; ev.tick = tick_num; ev.busy = busy_a; ev.prev_busy = prev_busy_a;
                q_a.push_back(ev);
            end
            if (flag_b) begin
                ev.data = data_b; ev.tick = tick_num; ev.busy = busy_b; ev.prev_busy = prev_busy_b;
                q_b.push_back(ev);
            end
            prev_busy_a = busy_a;
            prev_busy_b = busy_b;
        end
    end

    // Line sequence for the default format: start, data LSB first, parity, stop.
    function automatic logic [15:0] make_line_a(input logic [7:0] d, input logic p, input logic s);
        logic [15:0] b;
        b = '1;
        b[0] = 1'b0;
        for (int i = 0; i < 8; i++) b[1 + i] = d[i];
        b[9]  = p;
        b[10] = s;
        return b;
    endfunction

    function automatic logic [15:0] make_line_b(input logic [7:0] d);
        logic [15:0] b;
        b = '1;
        b[0] = 1'b0;
        for (int i = 0; i < 8; i++) b[1 + i] = d[i];
        return b;
    endfunction

    function automatic logic [10:0] exp_a(input logic [7:0] d, input logic p, input logic s);
        int v;
        v = int'(d) * 2 + int'(p) * 512 + int'(s) * 1024;
        return v[10:0];
    endfunction

    function automatic logic [10:0] exp_b(input logic [7:0] d);
        int v;
        v = int'(d) * 2 + 512 + 1024;
        return v[10:0];
    endfunction

    task automatic wait_tick();
        do @(posedge clk); while (!baud_tick);
        #1;
    endtask

    task automatic set_line(input int sel, input logic v);
        if (sel == 0) rx_a = v;
        else          rx_b = v;
    endtask

    // Each bit is held for os ticks; returns aligned just after the last tick so a
    // following call starts the next frame with no gap.
    task automatic drive_bits(input int sel, input logic [15:0] line, input int n, input int os,
                              output int t0);
        t0 = tick_num;
        for (int i = 0; i < n; i++) begin
            set_line(sel, line[i]);
            repeat (os) wait_tick();
        end
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        rx_a = 1'b1;
        rx_b = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        q_a.delete();
        q_b.delete();
        wait_tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (data_a !== 11'h7FF) begin failures++; $display("FAIL reset_data_a: got %h expected 7ff", data_a); end
        checks++; if (flag_a !== 1'b0) begin failures++; $display("FAIL reset_flag_a: got %b expected 0", flag_a); end
        checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL reset_busy_a: got %b expected 0", busy_a); end
        checks++; if (data_b !== 11'h7FF) begin failures++; $display("FAIL reset_data_b: got %h expected 7ff", data_b); end
        $display("reset: data_a=%h flag_a=%b busy_a=%b data_b=%h", data_a, flag_a, busy_a, data_b);
        do_reset();
    endtask

    task automatic test_valid();
        int t0;
        int lat;
        do_reset();
        drive_bits(0, make_line_a(8'hA5, 1'b0, 1'b1), FW, OS_A, t0);
        repeat (4) wait_tick();
        checks++; if (q_a.size() !== 1) begin failures++; $display("FAIL valid_flag_count: got %0d expected 1", q_a.size()); end
        if (q_a.size() >= 1) begin
            lat = q_a[0].tick - t0;
            checks++; if (q_a[0].data !== exp_a(8'hA5, 1'b0, 1'b1)) begin failures++; $display("FAIL valid_data: got %h expected %h", q_a[0].data, exp_a(8'hA5, 1'b0, 1'b1)); end
            checks++; if (lat !== OS_A / 2 + (FW - 1) * OS_A) begin failures++; $display("FAIL valid_latency: got %0d ticks expected %0d", lat, OS_A / 2 + (FW - 1) * OS_A); end
            checks++; if (q_a[0].busy !== 1'b0 || q_a[0].prev_busy !== 1'b1) begin failures++; $display("FAIL valid_busy_fall: got busy %b prev %b expected 0 prev 1", q_a[0].busy, q_a[0].prev_busy); end
            $display("valid: data=%h latency=%0d ticks", q_a[0].data, lat);
        end
        checks++; if (data_a !== 11'h54A) begin failures++; $display("FAIL valid_hold: got %h expected 54a", data_a); end
    endtask

    task automatic test_false_start();
        do_reset();
        rx_a = 1'b0;
        repeat (4) wait_tick();
        checks++; if (busy_a !== 1'b1) begin failures++; $display("FAIL false_busy_high: got %b expected 1", busy_a); end
        rx_a = 1'b1;
        repeat (9) wait_tick();
        checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL false_busy_low: got %b expected 0", busy_a); end
        checks++; if (q_a.size() !== 0) begin failures++; $display("FAIL false_no_flag: got %0d flags expected 0", q_a.size()); end
        checks++; if (data_a !== 11'h7FF) begin failures++; $display("FAIL false_data: got %h expected 7ff", data_a); end
        $display("false_start: busy=%b flags=%0d data=%h", busy_a, q_a.size(), data_a);
    endtask

    task automatic test_back_to_back();
        int t0;
        int t1;
        int tdum;
        logic [15:0] l2;
        do_reset();
        drive_bits(0, make_line_a(8'h3C, ^8'h3C, 1'b1), FW, OS_A, t0);
        l2 = make_line_a(8'hFF, ^8'hFF, 1'b1);
        drive_bits(0, l2, 6, OS_A, t1);
        checks++; if (data_a !== 11'h478) begin failures++; $display("FAIL b2b_hold: got %h expected 478", data_a); end
        drive_bits(0, l2 >> 6, 5, OS_A, tdum);
        repeat (2) wait_tick();
        checks++; if (q_a.size() !== 2) begin failures++; $display("FAIL b2b_flag_count: got %0d expected 2", q_a.size()); end
        if (q_a.size() >= 2) begin
            checks++; if (q_a[0].data !== exp_a(8'h3C, ^8'h3C, 1'b1)) begin failures++; $display("FAIL b2b_first: got %h expected %h", q_a[0].data, exp_a(8'h3C, ^8'h3C, 1'b1)); end
            checks++; if (q_a[1].data !== exp_a(8'hFF, ^8'hFF, 1'b1)) begin failures++; $display("FAIL b2b_second: got %h expected %h", q_a[1].data, exp_a(8'hFF, ^8'hFF, 1'b1)); end
            checks++; if (q_a[1].tick - q_a[0].tick !== t1 - t0) begin failures++; $display("FAIL b2b_spacing: got %0d ticks expected %0d", q_a[1].tick - q_a[0].tick, t1 - t0); end
            $display("back_to_back: %h then %h spacing=%0d ticks", q_a[0].data, q_a[1].data, q_a[1].tick - q_a[0].tick);
        end
    endtask

    task automatic test_break();
        int t0;
        do_reset();
        drive_bits(0, 16'h0000, FW, OS_A, t0);
        repeat (3 * FW * OS_A) wait_tick();
        checks++; if (q_a.size() !== 1) begin failures++; $display("FAIL break_flag_count: got %0d expected 1", q_a.size()); end
        if (q_a.size() >= 1) begin
            checks++; if (q_a[0].data !== 11'h000) begin failures++; $display("FAIL break_data: got %h expected 000", q_a[0].data); end
        end
        checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL break_busy: got %b expected 0", busy_a); end
        rx_a = 1'b1;
        repeat (20) wait_tick();
        drive_bits(0, make_line_a(8'hA5, 1'b0, 1'b1), FW, OS_A, t0);
        repeat (2) wait_tick();
        checks++; if (q_a.size() !== 2) begin failures++; $display("FAIL break_recover_count: got %0d expected 2", q_a.size()); end
        if (q_a.size() >= 2) begin
            checks++; if (q_a[1].data !== 11'h54A) begin failures++; $display("FAIL break_recover_data: got %h expected 54a", q_a[1].data); end
        end
        $display("break: flags=%0d data=%h", q_a.size(), data_a);
    endtask

    task automatic test_reset_mid();
        int t0;
        logic [15:0] l;
        do_reset();
        drive_bits(0, make_line_a(8'h3C, ^8'h3C, 1'b1), FW, OS_A, t0);
        l = make_line_a(8'hA5, 1'b0, 1'b1);
        drive_bits(0, l, 5, OS_A, t0);
        rx_a = l[5];
        repeat (8) wait_tick();
        checks++; if (busy_a !== 1'b1) begin failures++; $display("FAIL rstmid_busy_before: got %b expected 1", busy_a); end
        rst  = 1'b1;
        rx_a = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL rstmid_busy: got %b expected 0", busy_a); end
        checks++; if (data_a !== 11'h7FF) begin failures++; $display("FAIL rstmid_data: got %h expected 7ff", data_a); end
        checks++; if (flag_a !== 1'b0) begin failures++; $display("FAIL rstmid_flag: got %b expected 0", flag_a); end
        rst = 1'b0;
        repeat (40) wait_tick();
        checks++; if (q_a.size() !== 1) begin failures++; $display("FAIL rstmid_no_flag: got %0d flags expected 1", q_a.size()); end
        drive_bits(0, l, FW, OS_A, t0);
        repeat (2) wait_tick();
        checks++; if (q_a.size() !== 2) begin failures++; $display("FAIL rstmid_next_count: got %0d expected 2", q_a.size()); end
        if (q_a.size() >= 2) begin
            checks++; if (q_a[1].data !== 11'h54A) begin failures++; $display("FAIL rstmid_next_data: got %h expected 54a", q_a[1].data); end
        end
        $display("reset_mid: flags=%0d data=%h", q_a.size(), data_a);
    endtask

    task automatic test_alt_params();
        int t0;
        int lat;
        do_reset();
        drive_bits(1, make_line_b(8'h81), FW, OS_B, t0);
        repeat (2) wait_tick();
        checks++; if (q_b.size() !== 1) begin failures++; $display("FAIL alt_flag_count: got %0d expected 1", q_b.size()); end
        if (q_b.size() >= 1) begin
            lat = q_b[0].tick - t0;
            checks++; if (q_b[0].data !== exp_b(8'h81)) begin failures++; $display("FAIL alt_data: got %h expected %h", q_b[0].data, exp_b(8'h81)); end
            checks++; if (lat !== OS_B / 2 + (FW - 1) * OS_B) begin failures++; $display("FAIL alt_latency: got %0d ticks expected %0d", lat, OS_B / 2 + (FW - 1) * OS_B); end
            $display("alt_params: data=%h latency=%0d ticks", q_b[0].data, lat);
        end
        checks++; if (q_a.size() !== 0) begin failures++; $display("FAIL alt_isolation: got %0d flags on default unit expected 0", q_a.size()); end
    endtask

    task automatic test_random();
        int t0;
        logic [7:0]  d;
        logic        p;
        logic [10:0] exp_q[$];
        logic [10:0] expb_q[$];
        do_reset();
        for (int k = 0; k < 8; k++) begin
            d = 8'($urandom);
            p = 1'($urandom);
            repeat ($urandom_range(0, 12)) wait_tick();
            drive_bits(0, make_line_a(d, p, 1'b1), FW, OS_A, t0);
            exp_q.push_back(exp_a(d, p, 1'b1));
        end
        for (int k = 0; k < 4; k++) begin
            d = 8'($urandom);
            repeat ($urandom_range(0, 6)) wait_tick();
            drive_bits(1, make_line_b(d), FW, OS_B, t0);
            expb_q.push_back(exp_b(d));
        end
        repeat (2) wait_tick();
        checks++; if (q_a.size() !== exp_q.size()) begin failures++; $display("FAIL rand_count_a: got %0d expected %0d", q_a.size(), exp_q.size()); end
        checks++; if (q_b.size() !== expb_q.size()) begin failures++; $display("FAIL rand_count_b: got %0d expected %0d", q_b.size(), expb_q.size()); end
        for (int k = 0; k < exp_q.size() && k < q_a.size(); k++) begin
            checks++; if (q_a[k].data !== exp_q[k]) begin failures++; $display("FAIL rand_a_%0d: got %h expected %h", k, q_a[k].data, exp_q[k]); end
            $display("random_a[%0d]: got %h expected %h", k, q_a[k].data, exp_q[k]);
        end
        for (int k = 0; k < expb_q.size() && k < q_b.size(); k++) begin
            checks++; if (q_b[k].data !== expb_q[k]) begin failures++; $display("FAIL rand_b_%0d: got %h expected %h", k, q_b[k].data, expb_q[k]); end
            $display("random_b[%0d]: got %h expected %h", k, q_b[k].data, expb_q[k]);
        end
    endtask

    initial begin
        test_reset();
        test_valid();
        test_false_start();
        test_back_to_back();
        test_break();
        test_reset_mid();
        test_alt_params();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
